dma_move_sequencer: RTL
=======================

// Module: dma_move_sequencer
// PURPOSE
//  Multi-channel transfer front end for the Reader/PeekQueue/Writer data mover.
//  Round-robin arbitrates NUM_CH channel move commands (src, dst, len) and splits each
//  granted move into a paired Reader cmd and Writer cmd. Merges the two statuses into
//  one per-channel status. Adds what the bare mover lacks: alignment check, zero-length
//  bypass, per-channel abort and queue flush on abort/error.
// PARAMETERS
//  NUM_CH  4   number of requesting channels (>=1)
//  ADDR_W  32  byte address width
//  LEN_W   24  byte length width
// PORTS
//  ACLK        in   1              clock; single clock domain
//  ARESETn     in   1              asynchronous active-low reset
//  ChCmdValid  in   NUM_CH         per-channel move command valid
//  ChCmdReady  out  NUM_CH         per-channel accept, one-hot, one cycle
//  ChCmdSrc    in   NUM_CH*ADDR_W  source address, channel i at [i*ADDR_W +: ADDR_W]
//  ChCmdDst    in   NUM_CH*ADDR_W  destination address, same packing
//  ChCmdLen    in   NUM_CH*LEN_W   length in bytes
//  ChAbort     in   NUM_CH         abort request, sampled for the active channel only
//  ChStatValid out  NUM_CH         status valid, one-hot, held until ready
//  ChStatReady in   NUM_CH         status accept
//  ChStatCode  out  3              MoveStat_t of the channel with StatValid set
//  RdCmdValid/RdCmdReady out/in 1; RdCmdAddr out ADDR_W; RdCmdLen out LEN_W  to Reader
//  RdStatValid/RdStatReady in/out 1; RdStatErr in 1                          from Reader
//  WrCmdValid/WrCmdReady out/in 1; WrCmdAddr out ADDR_W; WrCmdLen out LEN_W  to Writer
//  WrStatValid/WrStatReady in/out 1; WrStatErr in 1                          from Writer
//  QueueFlush  out  1              one-cycle pulse to PeekQueue Abort
// BEHAVIOUR
//  Reset: all valid/ready/flush outputs 0; ChStatCode 0; Rd/WrCmd* data 0;
//   RR pointer = 0; FSM = IDLE.
//  One move in flight at a time.
//  IDLE: if any ChCmdValid, RR grant g = first valid at or after pointer; assert
//   ChCmdReady[g] that cycle; capture src/dst/len; pointer <= g+1 mod NUM_CH.
//   Next state:
//   - CHECK, always.
//  CHECK (1 cycle):
//   - (src|dst|len)[2:0] != 0 -> code ALIGN_ERR, go REPORT.
//   - else len == 0 -> code OK, go REPORT.
//   - else go ISSUE.
//  ISSUE:
//   - RdCmdValid and WrCmdValid both rise the cycle after CHECK and are independent.
//   - Each drops after its own handshake; sent flags record it.
//   - Cmd data stays stable while its valid is high.
//   - Go WAIT when both sent.
//   - Abort in ISSUE before either is sent: drop both valids; code ABORTED; go REPORT;
//     no flush.
//   - Abort after exactly one is sent: the other is still issued (pair consistency),
//     abort is latched, and the FSM continues to WAIT.
//  WAIT:
//   - RdStatReady/WrStatReady held 1; each status is latched once (err bit plus got flag).
//   - Abort is latched here too.
//   - When both are got: if abort latched or any err, pulse QueueFlush for 1 cycle.
//   - Then go REPORT.
//  Code priority: ABORTED > RDWR_ERR (both) > RD_ERR > WR_ERR > OK.
//  REPORT: ChStatValid[g]=1 with ChStatCode until ChStatReady[g]; then IDLE.
//   - The next grant is possible in the cycle after the status handshake.
//  Latency:
//   - Cmd accept cycle N -> Rd/WrCmdValid at N+2.
//   - Zero-len or align error -> ChStatValid at N+2.
//   - Last status latched at M -> ChStatValid at M+1 (QueueFlush, if any, at M+1).
//  Boundaries:
//   - Rd/WrStat arriving outside WAIT: not accepted (ready 0).
//   - Both statuses in the same cycle: both latched.
//   - ChAbort on a non-active channel, or in IDLE/CHECK/REPORT: ignored.
//   - Abort and the last status in the same cycle: abort wins the code.
//   - Pointer wraps NUM_CH-1 -> 0.
//   - NUM_CH=1 degenerates to a fixed grant.
//   - ARESETn mid-move returns everything to reset. The whole DMA is reset together;
//     no draining.
// STRUCTURE
//  DmaPkg: typedef enum logic[2:0] MoveStat_t
//   {OK=0, RD_ERR=1, WR_ERR=2, RDWR_ERR=3, ABORTED=4, ALIGN_ERR=5};
//   localparam ALIGN_MASK = 3'b111; FSM state enum.
//  Sub-module dma_rr_arbiter #(N): req vector, advance strobe -> one-hot grant and
//   index; owns the pointer.
//  The mover path (Reader, PeekQueue, Writer) stays external; this block only drives
//   their cmd/stat ports and the queue Abort.
// TESTING
//  1. ch1 src=0x1000 dst=0x2000 len=0x40; both stats err=0 -> Rd/WrCmd carry
//     those values, ch1 status OK, no QueueFlush.
//  2. ch0..ch3 valid together, pointer=0, each status returned -> grant order
//     0,1,2,3; then ch0 and ch2 valid -> ch0 next (wrap).
//  3. ch2 src=0x1004 -> ALIGN_ERR at accept+2, no Rd/WrCmdValid.
//     ch2 len=0 -> OK at accept+2, no cmds.
//  4. WrCmdReady held 0, RdCmd sent, ChAbort[g] pulsed -> WrCmd still issued,
//     both stats awaited, 1-cycle QueueFlush, code ABORTED.
//  5. RdStatErr=1 and WrStatErr=1 in the same cycle -> both latched, QueueFlush,
//     code RDWR_ERR. WrStatErr alone -> WR_ERR plus flush.
//  6. ARESETn low during WAIT -> all outputs 0 immediately; after release, a new
//     cmd is granted from ch0.

Source files
------------

// File: rtl/dma_move_sequencer_pkg.sv
// Shared types for the DMA move sequencer: status codes, FSM states and the
// status-merge priority used when a paired Reader/Writer move completes.
package dma_move_sequencer_pkg;

    typedef enum logic [2:0] {
        OK        = 3'd0,
        RD_ERR    = 3'd1,
        WR_ERR    = 3'd2,
        RDWR_ERR  = 3'd3,
        ABORTED   = 3'd4,
        ALIGN_ERR = 3'd5
    } MoveStat_t;

    localparam logic [2:0] ALIGN_MASK = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_REPORT = 3'd4
    } move_state_t;

    // Abort dominates; a double error is reported distinctly from single-side errors.
    function automatic MoveStat_t merge_status(input logic aborted,
                                               input logic rd_err,
                                               input logic wr_err);
        if (aborted)               return ABORTED;
        else if (rd_err && wr_err) return RDWR_ERR;
        else if (rd_err)           return RD_ERR;
        else if (wr_err)           return WR_ERR;
        else                       return OK;
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner when the caller takes the grant.
module dma_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q;

    assign any_o = |req_i;

    always_comb begin
        int  c;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        c           = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_q) + k;
            if (c >= N) c = c - N;
            if (!found && req_i[c]) begin
                found       = 1'b1;
                grant_o[c]  = 1'b1;
                grant_idx_o = IW'(c);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i && any_o) begin
            ptr_q <= (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
        end
    end

endmodule

// File: rtl/dma_move_sequencer.sv
// Multi-channel front end for the Reader/PeekQueue/Writer mover: arbitrates channel
// moves, issues paired Reader/Writer commands, merges their statuses, handles abort.
module dma_move_sequencer
    import dma_move_sequencer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 24
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [NUM_CH-1:0]        ChCmdValid,
    output logic [NUM_CH-1:0]        ChCmdReady,
    input  logic [NUM_CH*ADDR_W-1:0] ChCmdSrc,
    input  logic [NUM_CH*ADDR_W-1:0] ChCmdDst,
    input  logic [NUM_CH*LEN_W-1:0]  ChCmdLen,
    input  logic [NUM_CH-1:0]        ChAbort,
    output logic [NUM_CH-1:0]        ChStatValid,
    input  logic [NUM_CH-1:0]        ChStatReady,
    output logic [2:0]               ChStatCode,
    output logic                     RdCmdValid,
    input  logic                     RdCmdReady,
    output logic [ADDR_W-1:0]        RdCmdAddr,
    output logic [LEN_W-1:0]         RdCmdLen,
    input  logic                     RdStatValid,
    output logic                     RdStatReady,
    input  logic                     RdStatErr,
    output logic                     WrCmdValid,
    input  logic                     WrCmdReady,
    output logic [ADDR_W-1:0]        WrCmdAddr,
    output logic [LEN_W-1:0]         WrCmdLen,
    input  logic                     WrStatValid,
    output logic                     WrStatReady,
    input  logic                     WrStatErr,
    output logic                     QueueFlush
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Handshakes are valid/ready: a transfer happens on a rising ACLK edge where
    // both are high; a valid, once raised, holds its data until that edge.

    move_state_t         state_q;
    logic [NUM_CH-1:0]   gnt_oh_q;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [LEN_W-1:0]    len_q;
    logic                rd_valid_q, wr_valid_q;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    logic [LEN_W-1:0]    rd_len_q, wr_len_q;
    logic                rd_sent_q, wr_sent_q;
    logic                rd_got_q, wr_got_q;
    logic                rd_err_q, wr_err_q;
    logic                abort_q;
    logic                stat_ready_q;
    logic                stat_valid_q;
    MoveStat_t           code_q;
    logic                flush_q;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [ADDR_W-1:0]   sel_src, sel_dst;
    logic [LEN_W-1:0]    sel_len;

    logic rd_hs, wr_hs, act_abort, stat_ack;
    logic rd_sent_d, wr_sent_d, rd_got_d, wr_got_d, rd_err_d, wr_err_d, abort_d;

    dma_rr_arbiter #(.N(NUM_CH), .IW(IDX_W)) u_arb (
        .clk_i       (ACLK),
        .rst_ni      (ARESETn),
        .req_i       (ChCmdValid),
        .advance_i   (state_q == S_IDLE),
        .grant_o     (arb_gnt),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        sel_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_src = ChCmdSrc[i*ADDR_W +: ADDR_W];
                sel_dst = ChCmdDst[i*ADDR_W +: ADDR_W];
                sel_len = ChCmdLen[i*LEN_W +: LEN_W];
            end
        end
    end

    assign rd_hs     = rd_valid_q & RdCmdReady;
    assign wr_hs     = wr_valid_q & WrCmdReady;
    assign act_abort = |(ChAbort & gnt_oh_q);
    assign stat_ack  = |(ChStatReady & gnt_oh_q);

    // Each status is taken only once; repeats while still in WAIT are ignored.
    assign rd_sent_d = rd_sent_q | rd_hs;
    assign wr_sent_d = wr_sent_q | wr_hs;
    assign rd_got_d  = rd_got_q | RdStatValid;
    assign wr_got_d  = wr_got_q | WrStatValid;
    assign rd_err_d  = rd_got_q ? rd_err_q : (RdStatValid & RdStatErr);
    assign wr_err_d  = wr_got_q ? wr_err_q : (WrStatValid & WrStatErr);
    assign abort_d   = abort_q | act_abort;

    assign ChCmdReady  = (state_q == S_IDLE && ARESETn) ? arb_gnt : '0;
    assign ChStatValid = stat_valid_q ? gnt_oh_q : '0;
    assign ChStatCode  = code_q;
    assign RdCmdValid  = rd_valid_q;
    assign RdCmdAddr   = rd_addr_q;
    assign RdCmdLen    = rd_len_q;
    assign WrCmdValid  = wr_valid_q;
    assign WrCmdAddr   = wr_addr_q;
    assign WrCmdLen    = wr_len_q;
    assign RdStatReady = stat_ready_q;
    assign WrStatReady = stat_ready_q;
    assign QueueFlush  = flush_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= S_IDLE;
            gnt_oh_q     <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            rd_valid_q   <= 1'b0;
            wr_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            rd_len_q     <= '0;
            wr_len_q     <= '0;
            rd_sent_q    <= 1'b0;
            wr_sent_q    <= 1'b0;
            rd_got_q     <= 1'b0;
            wr_got_q     <= 1'b0;
            rd_err_q     <= 1'b0;
            wr_err_q     <= 1'b0;
            abort_q      <= 1'b0;
            stat_ready_q <= 1'b0;
            stat_valid_q <= 1'b0;
            code_q       <= OK;
            flush_q      <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arb_any) begin
                        gnt_oh_q <= arb_gnt;
                        src_q    <= sel_src;
                        dst_q    <= sel_dst;
                        len_q    <= sel_len;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    rd_sent_q <= 1'b0;
                    wr_sent_q <= 1'b0;
                    rd_got_q  <= 1'b0;
                    wr_got_q  <= 1'b0;
                    rd_err_q  <= 1'b0;
                    wr_err_q  <= 1'b0;
                    abort_q   <= 1'b0;
                    if (((src_q[2:0] | dst_q[2:0] | len_q[2:0]) & ALIGN_MASK) != 3'b000) begin
                        code_q       <= ALIGN_ERR;
                        stat_valid_q <= 1'b1;
                        state_q      <= S_REPORT;
                    end else if (len_q == '0) begin
                        code_q       <= OK;
                        stat_valid_q <= 1'b1;
                        state_q      <= S_REPORT;
                    end else begin
                        rd_valid_q <= 1'b1;
                        wr_valid_q <= 1'b1;
                        rd_addr_q  <= src_q;
                        rd_len_q   <= len_q;
                        wr_addr_q  <= dst_q;
                        wr_len_q   <= len_q;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (rd_hs) begin
                        rd_valid_q <= 1'b0;
                        rd_sent_q  <= 1'b1;
                    end
                    if (wr_hs) begin
                        wr_valid_q <= 1'b0;
                        wr_sent_q  <= 1'b1;
                    end
                    // A command handed over on the abort edge counts as sent, so the
                    // pair is completed rather than leaving one side orphaned.
                    if (act_abort && !rd_sent_d && !wr_sent_d) begin
                        rd_valid_q   <= 1'b0;
                        wr_valid_q   <= 1'b0;
                        code_q       <= ABORTED;
                        stat_valid_q <= 1'b1;
                        state_q      <= S_REPORT;
                    end else begin
                        abort_q <= abort_d;
                        if (rd_sent_d && wr_sent_d) begin
                            stat_ready_q <= 1'b1;
                            state_q      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    rd_got_q <= rd_got_d;
                    wr_got_q <= wr_got_d;
                    rd_err_q <= rd_err_d;
                    wr_err_q <= wr_err_d;
                    abort_q  <= abort_d;
                    if (rd_got_d && wr_got_d) begin
                        stat_ready_q <= 1'b0;
                        stat_valid_q <= 1'b1;
                        code_q       <= merge_status(abort_d, rd_err_d, wr_err_d);
                        flush_q      <= abort_d | rd_err_d | wr_err_d;
                        state_q      <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (stat_ack) begin
                        stat_valid_q <= 1'b0;
                        code_q       <= OK;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
